// File: rtl/lbm_step_scheduler.sv
// Timestep sequencer for the lattice-Boltzmann datapath: sweeps the lattice once per step,
// ping-pongs the banks, and lends the single BRAM read port to the frame readout streamer.
module lbm_step_scheduler #(
    parameter int DEPTH         = 2500,
    parameter int ADDRESS_WIDTH = 12,
    parameter int STEP_WIDTH    = 16
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic                     start,
    input  logic [STEP_WIDTH-1:0]    num_steps,
    input  logic [7:0]               out_interval,
    output logic                     busy,
    output logic                     done,
    output logic [STEP_WIDTH-1:0]    step_count,
    output logic                     bank_sel,
    output logic [ADDRESS_WIDTH-1:0] cmp_addr,
    output logic                     cmp_valid,
    input  logic                     cmp_ready,
    input  logic                     cmp_drained,
    output logic                     rd_frame_ready,
    input  logic [ADDRESS_WIDTH-1:0] rd_addr,
    input  logic                     rd_frame_done,
    output logic [ADDRESS_WIDTH-1:0] bram_rd_addr,
    output logic                     bram_rd_en,
    output logic                     port_owner,
    output logic [2:0]               fsm_state
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SWEEP     = 3'd1,
        S_DRAIN     = 3'd2,
        S_SWAP      = 3'd3,
        S_DUMP_REQ  = 3'd4,
        S_DUMP_WAIT = 3'd5,
        S_FINISH    = 3'd6
    } state_t;

    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH - 1);

    state_t                  state;
    state_t                  state_next;
    logic [STEP_WIDTH-1:0]   num_q;
    logic [7:0]              int_q;
    logic [7:0]              int_cnt;
    logic [STEP_WIDTH-1:0]   step_inc;
    logic [7:0]              int_inc;
    logic                    int_hit;
    logic                    last_beat;

    assign step_inc  = step_count + 1'b1;
    assign int_inc   = int_cnt + 1'b1;
    assign int_hit   = (int_q != 8'd0) && (int_inc == int_q);
    // cmp handshake: a transfer happens on a cycle where cmp_valid && cmp_ready;
    // cmp_addr is held stable while cmp_valid is high and cmp_ready is low.
    assign last_beat = cmp_ready && (cmp_addr == LAST_ADDR);
    assign fsm_state = state;

    always_ff @(posedge aclk) begin
        if (areset) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:      if (start) state_next = (num_steps == '0) ? S_FINISH : S_SWEEP;
            S_SWEEP:     if (last_beat) state_next = S_DRAIN;
            S_DRAIN:     if (cmp_drained) state_next = S_SWAP;
            S_SWAP:      state_next = ((step_inc == num_q) || int_hit) ? S_DUMP_REQ : S_SWEEP;
            S_DUMP_REQ:  state_next = S_DUMP_WAIT;
            S_DUMP_WAIT: if (rd_frame_done) state_next = (step_count == num_q) ? S_FINISH : S_SWEEP;
            S_FINISH:    state_next = S_IDLE;
            default:     state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy           = (state != S_IDLE);
        done           = (state == S_FINISH);
        cmp_valid      = (state == S_SWEEP);
        rd_frame_ready = (state == S_DUMP_REQ);
        port_owner     = (state == S_DUMP_REQ) || (state == S_DUMP_WAIT);
    end

    // Port arbitration: the readout streamer owns the port only during the dump phase.
    always_comb begin
        if (port_owner) begin
            bram_rd_addr = rd_addr;
            bram_rd_en   = 1'b1;
        end else begin
            bram_rd_addr = cmp_addr;
            bram_rd_en   = cmp_valid && cmp_ready;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            num_q      <= '0;
            int_q      <= '0;
            int_cnt    <= '0;
            step_count <= '0;
            bank_sel   <= 1'b0;
            cmp_addr   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        num_q      <= num_steps;
                        int_q      <= out_interval;
                        int_cnt    <= '0;
                        step_count <= '0;
                        cmp_addr   <= '0;
                    end
                end
                S_SWEEP: begin
                    if (cmp_ready) cmp_addr <= last_beat ? '0 : cmp_addr + 1'b1;
                end
                S_SWAP: begin
                    bank_sel   <= ~bank_sel;
                    step_count <= step_inc;
                    int_cnt    <= int_hit ? 8'd0 : int_inc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lbm_step_scheduler.sv
// Directed bench for lbm_step_scheduler: full runs with dumps, random back-pressure,
// drain stalls, dump-phase arbitration, mid-run reset and zero-step runs.
module tb_lbm_step_scheduler;

    localparam int DEPTH = 2500;
    localparam int AW    = 12;
    localparam int SW    = 16;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_SWEEP     = 3'd1;
    localparam logic [2:0] S_DRAIN     = 3'd2;
    localparam logic [2:0] S_SWAP      = 3'd3;
    localparam logic [2:0] S_DUMP_REQ  = 3'd4;
    localparam logic [2:0] S_DUMP_WAIT = 3'd5;
    localparam logic [2:0] S_FINISH    = 3'd6;

    logic          aclk = 1'b0;
    logic          areset = 1'b1;
    logic          start = 1'b0;
    logic [SW-1:0] num_steps = '0;
    logic [7:0]    out_interval = '0;
    logic          busy, done, bank_sel, cmp_valid, rd_frame_ready, bram_rd_en, port_owner;
    logic [SW-1:0] step_count;
    logic [AW-1:0] cmp_addr, bram_rd_addr;
    logic          cmp_ready = 1'b1;
    logic          cmp_drained = 1'b1;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_frame_done = 1'b0;
    logic [2:0]    fsm_state;

    int n_checks = 0;
    int n_fail = 0;
    int rd_pulses = 0;
    int done_pulses = 0;
    logic exp_bank = 1'b0;

    lbm_step_scheduler #(.DEPTH(DEPTH), .ADDRESS_WIDTH(AW), .STEP_WIDTH(SW)) dut (
        .aclk(aclk), .areset(areset), .start(start), .num_steps(num_steps),
        .out_interval(out_interval), .busy(busy), .done(done), .step_count(step_count),
        .bank_sel(bank_sel), .cmp_addr(cmp_addr), .cmp_valid(cmp_valid), .cmp_ready(cmp_ready),
        .cmp_drained(cmp_drained), .rd_frame_ready(rd_frame_ready), .rd_addr(rd_addr),
        .rd_frame_done(rd_frame_done), .bram_rd_addr(bram_rd_addr), .bram_rd_en(bram_rd_en),
        .port_owner(port_owner), .fsm_state(fsm_state)
    );

    // clock / reset
    always #5 aclk = ~aclk;

    always @(posedge aclk) begin
        if (rd_frame_ready === 1'b1) rd_pulses <= rd_pulses + 1;
        if (done === 1'b1) done_pulses <= done_pulses + 1;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time exhausted, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    task automatic wait_state(input logic [2:0] target, input string name);
        int cyc = 0;
        while (fsm_state !== target && cyc < 200) begin
            @(negedge aclk);
            cyc++;
        end
        n_checks++;
        if (fsm_state !== target) begin
            n_fail++;
            $display("FAIL %s: state=%0d expected=%0d", name, fsm_state, target);
        end
    endtask

    // Drives cmp_ready with pct% probability until the sweep ends; counts read
    // pulses and cycles where address/enable/ownership disagree with the bench's address.
    task automatic run_sweep(input int pct, output int pulses, output int errs);
        int exp_a = 0;
        int cyc = 0;
        pulses = 0;
        errs = 0;
        while (fsm_state === S_SWEEP && cyc < 4 * DEPTH + 100) begin
            cmp_ready = ($urandom_range(99) < pct);
            #1;
            if (cmp_addr !== AW'(exp_a) || bram_rd_addr !== AW'(exp_a) ||
                bram_rd_en !== cmp_ready || cmp_valid !== 1'b1 || port_owner !== 1'b0)
                errs++;
            if (cmp_ready) begin
                pulses++;
                exp_a++;
            end
            @(negedge aclk);
            cyc++;
        end
        cmp_ready = 1'b1;
    endtask

    task automatic run_job(input int num, input int intv, input int pct, input string name);
        int pulses, errs, rd0, exp_dumps;
        bit dump_exp;
        rd0 = rd_pulses;
        exp_dumps = 0;
        num_steps = SW'(num);
        out_interval = 8'(intv);
        start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL %s_busy: got %b expected 1", name, busy); end
        for (int s = 1; s <= num; s++) begin
            wait_state(S_SWEEP, "sweep_entry");
            n_checks++;
            if (step_count !== SW'(s - 1) || bank_sel !== exp_bank) begin
                n_fail++;
                $display("FAIL %s_sweep_start: step=%0d bank=%b expected step=%0d bank=%b", name, step_count, bank_sel, s - 1, exp_bank);
            end
            run_sweep(pct, pulses, errs);
            n_checks++;
            if (pulses !== DEPTH || errs !== 0) begin
                n_fail++;
                $display("FAIL %s_sweep: pulses=%0d errs=%0d expected pulses=%0d errs=0", name, pulses, errs, DEPTH);
            end
            wait_state(S_SWAP, "swap_entry");
            n_checks++;
            if (step_count !== SW'(s - 1) || bank_sel !== exp_bank) begin
                n_fail++;
                $display("FAIL %s_swap_hold: step=%0d bank=%b expected step=%0d bank=%b", name, step_count, bank_sel, s - 1, exp_bank);
            end
            exp_bank = ~exp_bank;
            @(negedge aclk);
            dump_exp = (s == num) || (intv != 0 && (s % intv) == 0);
            n_checks++;
            if (dump_exp) begin
                exp_dumps++;
                if (fsm_state !== S_DUMP_REQ || rd_frame_ready !== 1'b1 || port_owner !== 1'b1 ||
                    bank_sel !== exp_bank || step_count !== SW'(s)) begin
                    n_fail++;
                    $display("FAIL %s_dump_req: state=%0d rfr=%b owner=%b bank=%b step=%0d expected state=4 rfr=1 owner=1 bank=%b step=%0d",
                             name, fsm_state, rd_frame_ready, port_owner, bank_sel, step_count, exp_bank, s);
                end
                @(negedge aclk);
                n_checks++;
                if (fsm_state !== S_DUMP_WAIT || rd_frame_ready !== 1'b0 || port_owner !== 1'b1 || bram_rd_en !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s_dump_wait: state=%0d rfr=%b owner=%b en=%b expected state=5 rfr=0 owner=1 en=1",
                             name, fsm_state, rd_frame_ready, port_owner, bram_rd_en);
                end
                rd_frame_done = 1'b1;
                @(negedge aclk);
                rd_frame_done = 1'b0;
            end else begin
                if (fsm_state !== S_SWEEP || port_owner !== 1'b0 || step_count !== SW'(s) || bank_sel !== exp_bank) begin
                    n_fail++;
                    $display("FAIL %s_no_dump: state=%0d owner=%b step=%0d bank=%b expected state=1 owner=0 step=%0d bank=%b",
                             name, fsm_state, port_owner, step_count, bank_sel, s, exp_bank);
                end
            end
        end
        n_checks++;
        if (fsm_state !== S_FINISH || done !== 1'b1 || busy !== 1'b1 || port_owner !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_finish: state=%0d done=%b busy=%b owner=%b expected state=6 done=1 busy=1 owner=0", name, fsm_state, done, busy, port_owner);
        end
        @(negedge aclk);
        n_checks++;
        if (fsm_state !== S_IDLE || done !== 1'b0 || busy !== 1'b0 || step_count !== SW'(num)) begin
            n_fail++;
            $display("FAIL %s_idle: state=%0d done=%b busy=%b step=%0d expected state=0 done=0 busy=0 step=%0d", name, fsm_state, done, busy, step_count, num);
        end
        n_checks++;
        if (rd_pulses - rd0 !== exp_dumps) begin
            n_fail++;
            $display("FAIL %s_dump_count: got %0d expected %0d", name, rd_pulses - rd0, exp_dumps);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        n_checks++;
        if (fsm_state !== S_IDLE || busy !== 1'b0 || done !== 1'b0 || step_count !== '0 || bank_sel !== 1'b0 ||
            cmp_addr !== '0 || cmp_valid !== 1'b0 || rd_frame_ready !== 1'b0 || port_owner !== 1'b0 || bram_rd_en !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: state=%0d busy=%b done=%b step=%0d bank=%b addr=%0d valid=%b rfr=%b owner=%b en=%b expected all zero",
                     name, fsm_state, busy, done, step_count, bank_sel, cmp_addr, cmp_valid, rd_frame_ready, port_owner, bram_rd_en);
        end
    endtask

    task automatic test_reset();
        areset = 1'b1;
        repeat (3) @(negedge aclk);
        check_reset_outputs("reset_values");
        areset = 1'b0;
        exp_bank = 1'b0;
        @(negedge aclk);
        check_reset_outputs("post_reset_idle");
    endtask

    task automatic test_drain_and_dump();
        int pulses, errs;
        cmp_drained = 1'b0;
        num_steps = SW'(1);
        out_interval = 8'd0;
        start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        wait_state(S_SWEEP, "drain_sweep_entry");
        // back-pressure holds the address; rd_frame_done is ignored while sweeping
        cmp_ready = 1'b0;
        rd_frame_done = 1'b1;
        errs = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            if (fsm_state !== S_SWEEP || cmp_addr !== '0 || port_owner !== 1'b0 || bram_rd_en !== 1'b0) errs++;
        end
        rd_frame_done = 1'b0;
        n_checks++;
        if (errs !== 0) begin n_fail++; $display("FAIL sweep_hold_ignore_done: errs=%0d expected 0", errs); end
        run_sweep(100, pulses, errs);
        n_checks++;
        if (pulses !== DEPTH || errs !== 0) begin n_fail++; $display("FAIL drain_sweep: pulses=%0d errs=%0d expected %0d 0", pulses, errs, DEPTH); end
        errs = 0;
        for (int i = 0; i < 20; i++) begin
            if (fsm_state !== S_DRAIN || bank_sel !== exp_bank || step_count !== '0 || cmp_valid !== 1'b0) errs++;
            @(negedge aclk);
        end
        n_checks++;
        if (errs !== 0) begin n_fail++; $display("FAIL drain_hold: errs=%0d expected 0", errs); end
        cmp_drained = 1'b1;
        wait_state(S_SWAP, "drain_release");
        exp_bank = ~exp_bank;
        @(negedge aclk);
        wait_state(S_DUMP_WAIT, "drain_dump_wait");
        // readout streamer owns the port; start is ignored while busy
        errs = 0;
        num_steps = SW'(5);
        start = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            rd_addr = AW'(DEPTH - 1 - i);
            #1;
            if (bram_rd_addr !== AW'(DEPTH - 1 - i) || bram_rd_en !== 1'b1 || port_owner !== 1'b1 || fsm_state !== S_DUMP_WAIT) errs++;
            @(negedge aclk);
        end
        start = 1'b0;
        n_checks++;
        if (errs !== 0) begin n_fail++; $display("FAIL readout_mux: errs=%0d expected 0", errs); end
        rd_frame_done = 1'b1;
        @(negedge aclk);
        rd_frame_done = 1'b0;
        n_checks++;
        if (fsm_state !== S_FINISH || done !== 1'b1 || step_count !== SW'(1) || bank_sel !== exp_bank) begin
            n_fail++;
            $display("FAIL start_ignored_finish: state=%0d done=%b step=%0d bank=%b expected 6 1 1 %b", fsm_state, done, step_count, bank_sel, exp_bank);
        end
        @(negedge aclk);
    endtask

    task automatic test_reset_mid_run();
        int pulses, errs, cyc, d0;
        num_steps = SW'(3);
        out_interval = 8'd0;
        start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        wait_state(S_SWEEP, "mid_first_sweep");
        run_sweep(100, pulses, errs);
        wait_state(S_SWAP, "mid_first_swap");
        exp_bank = ~exp_bank;
        @(negedge aclk);
        wait_state(S_SWEEP, "mid_second_sweep");
        cyc = 0;
        while (cmp_addr !== AW'(1234) && cyc < 3000) begin
            @(negedge aclk);
            cyc++;
        end
        n_checks++;
        if (cmp_addr !== AW'(1234) || step_count !== SW'(1)) begin
            n_fail++;
            $display("FAIL mid_reach_1234: addr=%0d step=%0d expected 1234 1", cmp_addr, step_count);
        end
        d0 = done_pulses;
        areset = 1'b1;
        @(negedge aclk);
        check_reset_outputs("mid_run_reset");
        areset = 1'b0;
        exp_bank = 1'b0;
        repeat (5) @(negedge aclk);
        n_checks++;
        if (done_pulses !== d0 || fsm_state !== S_IDLE) begin
            n_fail++;
            $display("FAIL mid_no_done: pulses=%0d state=%0d expected %0d 0", done_pulses, fsm_state, d0);
        end
        run_job(1, 3, 100, "after_reset");
    endtask

    task automatic test_zero_steps();
        int d0;
        d0 = done_pulses;
        num_steps = '0;
        out_interval = 8'd1;
        start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        n_checks++;
        if (fsm_state !== S_FINISH || done !== 1'b1 || cmp_valid !== 1'b0 || step_count !== '0) begin
            n_fail++;
            $display("FAIL zero_finish: state=%0d done=%b valid=%b step=%0d expected 6 1 0 0", fsm_state, done, cmp_valid, step_count);
        end
        @(negedge aclk);
        n_checks++;
        if (fsm_state !== S_IDLE || done !== 1'b0 || busy !== 1'b0 || done_pulses - d0 !== 1) begin
            n_fail++;
            $display("FAIL zero_idle: state=%0d done=%b busy=%b pulses=%0d expected 0 0 0 1", fsm_state, done, busy, done_pulses - d0);
        end
    endtask

    initial begin
        test_reset();
        run_job(2, 0, 100, "basic");
        run_job(4, 2, 100, "interval");
        run_job(2, 0, 50, "random_ready");
        test_drain_and_dump();
        test_reset_mid_run();
        test_zero_steps();
        run_job(1, 1, 100, "back_to_back");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
